// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM and MEM/WB pipeline registers, word-addressed data memory,
// branch resolution and the MEM/WB forwarding values fed back to EXE.
module mem_stage #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  wr_reg,
  input  logic        zero_flag,
  input  logic [4:0]  branch_target,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic        branch,
  input  logic        stall,
  input  logic        flush,
  output logic        pc_src,
  output logic [4:0]  pc_target,
  output logic        mem_fwd_en,
  output logic [4:0]  mem_fwd_reg,
  output logic [31:0] mem_fwd_data,
  output logic        wb_regwrite,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  wr_reg;
    logic        zero_flag;
    logic [4:0]  branch_target;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
  } ex_mem_t;

  ex_mem_t ex_in;
  ex_mem_t ex_mem;

  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] mem_idx;
  logic              misaligned;
  logic              mem_we;
  logic [31:0]       rdata;

  logic              wb_rw_q;
  logic [4:0]        wb_reg_q;
  logic              wb_m2r_q;
  logic [31:0]       wb_alu_q;
  logic [31:0]       wb_rdata_q;
  logic              err_q;

  always_comb begin
    ex_in               = '0;
    ex_in.alu_result    = alu_result;
    ex_in.store_data    = store_data;
    ex_in.wr_reg        = wr_reg;
    ex_in.zero_flag     = zero_flag;
    ex_in.branch_target = branch_target;
    ex_in.mem_read      = mem_read;
    ex_in.mem_write     = mem_write;
    ex_in.reg_write     = reg_write;
    ex_in.mem_to_reg    = mem_to_reg;
    ex_in.branch        = branch;
    // A flushed instruction keeps its data fields but loses every side effect.
    if (flush) begin
      ex_in.mem_read   = 1'b0;
      ex_in.mem_write  = 1'b0;
      ex_in.reg_write  = 1'b0;
      ex_in.mem_to_reg = 1'b0;
      ex_in.branch     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem <= '0;
    end else if (flush || !stall) begin
      ex_mem <= ex_in;
    end
  end

  assign mem_idx    = ex_mem.alu_result[ADDR_W+1:2];
  assign misaligned = (ex_mem.mem_read | ex_mem.mem_write) & (ex_mem.alu_result[1:0] != 2'b00);
  assign mem_we     = ex_mem.mem_write & ~stall & ~misaligned;
  assign rdata      = (ex_mem.mem_read & ~misaligned) ? mem[mem_idx] : 32'h0;

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= ex_mem.store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rw_q    <= 1'b0;
      wb_reg_q   <= '0;
      wb_m2r_q   <= 1'b0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
    end else if (!stall) begin
      wb_rw_q    <= ex_mem.reg_write;
      wb_reg_q   <= ex_mem.wr_reg;
      wb_m2r_q   <= ex_mem.mem_to_reg;
      wb_alu_q   <= ex_mem.alu_result;
      wb_rdata_q <= rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (misaligned) begin
      err_q <= 1'b1;
    end
  end

  assign pc_src       = ex_mem.branch & ex_mem.zero_flag;
  assign pc_target    = ex_mem.branch_target;
  // Loads never forward from MEM; the hazard unit stalls instead.
  assign mem_fwd_en   = ex_mem.reg_write & ~ex_mem.mem_read & (ex_mem.wr_reg != 5'd0);
  assign mem_fwd_reg  = ex_mem.wr_reg;
  assign mem_fwd_data = ex_mem.alu_result;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_m2r_q ? wb_rdata_q : wb_alu_q;
  assign wb_regwrite  = wb_rw_q & (wb_reg_q != 5'd0);
  assign misalign_err = err_q;

endmodule
